// File: rtl/hazard_scoreboard.sv
// Scoreboard-driven hazard unit for the 5-stage pipeline: Tuse/Tnew stall and forward
// decisions, a multiply/divide busy tracker and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int REG_AW      = 5,
    parameter int TW          = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] D_rs,
    input  logic [REG_AW-1:0] D_rt,
    input  logic [TW-1:0]     D_TuseRs,
    input  logic [TW-1:0]     D_TuseRt,
    input  logic              D_isMD,
    input  logic [REG_AW-1:0] E_rs,
    input  logic [REG_AW-1:0] E_rt,
    input  logic [REG_AW-1:0] E_wa,
    input  logic [TW-1:0]     E_Tnew,
    input  logic [REG_AW-1:0] M_rt,
    input  logic [REG_AW-1:0] M_wa,
    input  logic [TW-1:0]     M_Tnew,
    input  logic [REG_AW-1:0] W_wa,
    input  logic              E_mdStart,
    input  logic              E_isDiv,
    output logic              enableIFU,
    output logic              enableD,
    output logic              clearE,
    output logic [1:0]        DrsSel,
    output logic [1:0]        DrtSel,
    output logic [1:0]        ErsSel,
    output logic [1:0]        ErtSel,
    output logic [1:0]        MrtSel,
    output logic              mduBusy,
    output logic [CNT_W-1:0]  stallCount
);

    localparam int MDW = $clog2(DIV_CYCLES + 1);
    localparam logic [TW-1:0] TUSE_NONE = '1;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_E    = 2'd1,
        SEL_M    = 2'd2,
        SEL_W    = 2'd3
    } fwdSel_e;

    logic [MDW-1:0] mdCount;
    logic           stallRs;
    logic           stallRt;
    logic           stallMd;
    logic           stall;

    // Register $0 is hardwired, so a zero source never matches any writer.
    function automatic logic hits(input logic [REG_AW-1:0] wa, input logic [REG_AW-1:0] src);
        return (src != '0) && (wa == src);
    endfunction

    // Stall when a producer in E or M delivers later than the consumer needs it.
    function automatic logic needsStall(
        input logic [REG_AW-1:0] src, input logic [TW-1:0] tuse,
        input logic [REG_AW-1:0] eWa, input logic [TW-1:0] eTnew,
        input logic [REG_AW-1:0] mWa, input logic [TW-1:0] mTnew
    );
        return (tuse != TUSE_NONE) &&
               ((hits(eWa, src) && (tuse < eTnew)) || (hits(mWa, src) && (tuse < mTnew)));
    endfunction

    function automatic fwdSel_e dSel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] eWa, input logic [TW-1:0] eTnew,
        input logic [REG_AW-1:0] mWa, input logic [TW-1:0] mTnew,
        input logic [REG_AW-1:0] wWa
    );
        if (hits(eWa, src) && (eTnew == '0))      return SEL_E;
        else if (hits(mWa, src) && (mTnew == '0)) return SEL_M;
        else if (hits(wWa, src))                  return SEL_W;
        return SEL_NONE;
    endfunction

    always_comb begin
        stallRs   = needsStall(D_rs, D_TuseRs, E_wa, E_Tnew, M_wa, M_Tnew);
        stallRt   = needsStall(D_rt, D_TuseRt, E_wa, E_Tnew, M_wa, M_Tnew);
        stallMd   = D_isMD && (E_mdStart || mduBusy);
        stall     = stallRs || stallRt || stallMd;
        enableIFU = !stall;
        enableD   = !stall;
        clearE    = stall;
    end

    // E and M reuse the D chain with the stages above them masked off.
    always_comb begin
        DrsSel = dSel(D_rs, E_wa, E_Tnew, M_wa, M_Tnew, W_wa);
        DrtSel = dSel(D_rt, E_wa, E_Tnew, M_wa, M_Tnew, W_wa);
        ErsSel = dSel(E_rs, '0, '0, M_wa, M_Tnew, W_wa);
        ErtSel = dSel(E_rt, '0, '0, M_wa, M_Tnew, W_wa);
        MrtSel = dSel(M_rt, '0, '0, '0, '0, W_wa);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mdCount    <= '0;
            stallCount <= '0;
        end else begin
            if (E_mdStart)
                mdCount <= E_isDiv ? MDW'(DIV_CYCLES) : MDW'(MULT_CYCLES);
            else if (mdCount != '0)
                mdCount <= mdCount - MDW'(1);

            if (stall && (stallCount != '1))
                stallCount <= stallCount + CNT_W'(1);
        end
    end

    assign mduBusy = (mdCount != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// compared against a behavioural model of the stall, forwarding and busy rules.
module tb_hazard_scoreboard;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       D_rs, D_rt, E_rs, E_rt, E_wa, M_rt, M_wa, W_wa;
    logic [1:0]       D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
    logic             D_isMD, E_mdStart, E_isDiv;
    logic             enableIFU, enableD, clearE, mduBusy;
    logic [1:0]       DrsSel, DrtSel, ErsSel, ErtSel, MrtSel;
    logic [CNT_W-1:0] stallCount;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    int busyEnd = -1;
    int cnt     = 0;

    hazard_scoreboard #(
        .REG_AW(5), .TW(2), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt), .D_isMD(D_isMD),
        .E_rs(E_rs), .E_rt(E_rt), .E_wa(E_wa), .E_Tnew(E_Tnew),
        .M_rt(M_rt), .M_wa(M_wa), .M_Tnew(M_Tnew), .W_wa(W_wa),
        .E_mdStart(E_mdStart), .E_isDiv(E_isDiv),
        .enableIFU(enableIFU), .enableD(enableD), .clearE(clearE),
        .DrsSel(DrsSel), .DrtSel(DrtSel), .ErsSel(ErsSel), .ErtSel(ErtSel), .MrtSel(MrtSel),
        .mduBusy(mduBusy), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit modelBusy();
        return cyc <= busyEnd;
    endfunction

    // A consumer stalls if any in-flight producer of its register needs more cycles than it can wait.
    function automatic bit stallFor(input int src, input int tuse);
        int writers[2] = '{int'(E_wa), int'(M_wa)};
        int ready[2]   = '{int'(E_Tnew), int'(M_Tnew)};
        if (src == 0 || tuse == 3) return 1'b0;
        foreach (writers[i])
            if (writers[i] == src && ready[i] > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit modelStall();
        return stallFor(D_rs, D_TuseRs) || stallFor(D_rt, D_TuseRt) ||
               (D_isMD && (E_mdStart || modelBusy()));
    endfunction

    // Walk the younger-to-older producer list from a given stage; first ready match wins.
    function automatic logic [1:0] nearest(input int src, input int first);
        int writers[3] = '{int'(E_wa), int'(M_wa), int'(W_wa)};
        int ready[3]   = '{int'(E_Tnew), int'(M_Tnew), 0};
        if (src == 0) return 2'd0;
        for (int i = first; i < 3; i++)
            if (writers[i] == src && ready[i] == 0) return 2'(i + 1);
        return 2'd0;
    endfunction

    function automatic logic [17:0] expVec();
        bit st = modelStall();
        return {!st, !st, st, nearest(D_rs, 0), nearest(D_rt, 0), nearest(E_rs, 1),
                nearest(E_rt, 1), nearest(M_rt, 2), modelBusy(), 4'(cnt)};
    endfunction

    function automatic logic [17:0] dutVec();
        return {enableIFU, enableD, clearE, DrsSel, DrtSel, ErsSel, ErtSel, MrtSel,
                mduBusy, stallCount};
    endfunction

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        bit st = modelStall();
        @(posedge clk);
        if (!reset) begin
            busyEnd = -1;
            cnt     = 0;
        end else begin
            if (E_mdStart) busyEnd = cyc + (E_isDiv ? DIV_N : MULT_N);
            if (st && cnt < CNT_MAX) cnt++;
        end
        cyc++;
        #1;
    endtask

    task automatic clearInputs();
        {D_rs, D_rt, E_rs, E_rt, E_wa, M_rt, M_wa, W_wa} = '0;
        {D_TuseRs, D_TuseRt, E_Tnew, M_Tnew} = '0;
        {D_isMD, E_mdStart, E_isDiv} = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clearInputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        nChecks++;
        if (mduBusy !== 1'b0) begin
            nFails++; $display("FAIL reset_busy: got %b want 0", mduBusy);
        end
        nChecks++;
        if (stallCount !== '0) begin
            nFails++; $display("FAIL reset_count: got %0d want 0", stallCount);
        end
        nChecks++;
        if ({enableIFU, enableD, clearE, DrsSel, DrtSel, ErsSel, ErtSel, MrtSel} !== 13'b110_0000000000) begin
            nFails++;
            $display("FAIL reset_comb: got %b want 1100000000000",
                     {enableIFU, enableD, clearE, DrsSel, DrtSel, ErsSel, ErtSel, MrtSel});
        end
    endtask

    task automatic test_load_use();
        clearInputs();
        D_rs = 5'd8; D_TuseRs = 2'd1; E_wa = 5'd8; E_Tnew = 2'd2;
        #1;
        nChecks++;
        if ({clearE, enableD, enableIFU} !== 3'b100) begin
            nFails++; $display("FAIL load_use_stall: got clearE/enD/enF=%b want 100", {clearE, enableD, enableIFU});
        end
        tick();
        E_wa = 5'd0; E_Tnew = 2'd0; M_wa = 5'd8; M_Tnew = 2'd1;
        #1;
        nChecks++;
        if ({clearE, DrsSel} !== 3'b000) begin
            nFails++; $display("FAIL load_use_m: got clearE=%b DrsSel=%0d want 0 0", clearE, DrsSel);
        end
        tick();
        M_wa = 5'd0; M_Tnew = 2'd0; W_wa = 5'd8;
        #1;
        nChecks++;
        if (DrsSel !== 2'd3) begin
            nFails++; $display("FAIL load_use_w: got DrsSel=%0d want 3", DrsSel);
        end
        tick();
        #1;
        nChecks++;
        if (stallCount !== 4'(cnt)) begin
            nFails++; $display("FAIL load_use_count: got %0d want %0d", stallCount, cnt);
        end
    endtask

    task automatic test_branch();
        clearInputs();
        D_rt = 5'd9; D_TuseRt = 2'd0; E_wa = 5'd9; E_Tnew = 2'd1;
        #1;
        nChecks++;
        if (clearE !== 1'b1) begin
            nFails++; $display("FAIL branch_stall: got clearE=%b want 1", clearE);
        end
        tick();
        E_wa = 5'd0; E_Tnew = 2'd0; M_wa = 5'd9; M_Tnew = 2'd0;
        #1;
        nChecks++;
        if ({clearE, DrtSel} !== 3'b010) begin
            nFails++; $display("FAIL branch_fwd: got clearE=%b DrtSel=%0d want 0 2", clearE, DrtSel);
        end
        tick();
    endtask

    task automatic test_priority();
        clearInputs();
        E_wa = 5'd5; M_wa = 5'd5; W_wa = 5'd5; D_rs = 5'd5; E_rs = 5'd5;
        #1;
        nChecks++;
        if ({DrsSel, ErsSel} !== 4'b0110) begin
            nFails++; $display("FAIL prio_nearest: got DrsSel=%0d ErsSel=%0d want 1 2", DrsSel, ErsSel);
        end
        clearInputs();
        #1;
        nChecks++;
        if ({DrsSel, clearE} !== 3'b000) begin
            nFails++; $display("FAIL prio_zero: got DrsSel=%0d clearE=%b want 0 0", DrsSel, clearE);
        end
        M_rt = 5'd4; W_wa = 5'd4;
        #1;
        nChecks++;
        if (MrtSel !== 2'd3) begin
            nFails++; $display("FAIL prio_mrt: got MrtSel=%0d want 3", MrtSel);
        end
        clearInputs();
        D_rs = 5'd6; D_TuseRs = 2'd3; E_wa = 5'd6; E_Tnew = 2'd3;
        #1;
        nChecks++;
        if ({clearE, DrsSel} !== 3'b000) begin
            nFails++; $display("FAIL tuse_unused: got clearE=%b DrsSel=%0d want 0 0", clearE, DrsSel);
        end
        tick();
    endtask

    task automatic test_mdu();
        int busyCycles = 0;
        clearInputs();
        D_isMD = 1'b1; E_mdStart = 1'b1; E_isDiv = 1'b1;
        #1;
        nChecks++;
        if (clearE !== 1'b1) begin
            nFails++; $display("FAIL div_start_stall: got %b want 1", clearE);
        end
        tick();
        E_mdStart = 1'b0; E_isDiv = 1'b0;
        for (int k = 1; k <= DIV_N; k++) begin
            #1;
            nChecks++;
            if ({mduBusy, clearE} !== 2'b11) begin
                nFails++; $display("FAIL div_busy_%0d: got busy=%b clearE=%b want 1 1", k, mduBusy, clearE);
            end
            tick();
        end
        #1;
        nChecks++;
        if ({mduBusy, clearE} !== 2'b00) begin
            nFails++; $display("FAIL div_done: got busy=%b clearE=%b want 0 0", mduBusy, clearE);
        end
        D_isMD = 1'b0; E_mdStart = 1'b1;
        tick();
        E_mdStart = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (mduBusy === 1'b1) busyCycles++;
            tick();
        end
        nChecks++;
        if (busyCycles !== MULT_N) begin
            nFails++; $display("FAIL mult_len: got %0d busy cycles want %0d", busyCycles, MULT_N);
        end
    endtask

    task automatic test_reset_mid_div();
        clearInputs();
        D_isMD = 1'b1; E_mdStart = 1'b1; E_isDiv = 1'b1;
        tick();
        E_mdStart = 1'b0; E_isDiv = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        nChecks++;
        if ({mduBusy, stallCount, clearE} !== 6'b0_0000_0) begin
            nFails++;
            $display("FAIL reset_mid_div: got busy=%b count=%0d clearE=%b want 0 0 0", mduBusy, stallCount, clearE);
        end
        tick();
    endtask

    task automatic test_saturation();
        clearInputs();
        D_rs = 5'd8; D_TuseRs = 2'd0; E_wa = 5'd8; E_Tnew = 2'd2;
        for (int k = 0; k < 20; k++) begin
            tick();
            #1;
            nChecks++;
            if (stallCount !== 4'(cnt)) begin
                nFails++; $display("FAIL sat_%0d: got %0d want %0d", k, stallCount, cnt);
            end
        end
        nChecks++;
        if (stallCount !== 4'd15) begin
            nFails++; $display("FAIL sat_final: got %0d want 15", stallCount);
        end
    endtask

    task automatic test_random();
        logic [17:0] want;
        for (int k = 0; k < 400; k++) begin
            reset     = ($urandom_range(0, 49) != 0);
            D_rs      = 5'($urandom_range(0, 3));
            D_rt      = 5'($urandom_range(0, 3));
            E_rs      = 5'($urandom_range(0, 3));
            E_rt      = 5'($urandom_range(0, 3));
            E_wa      = 5'($urandom_range(0, 3));
            M_rt      = 5'($urandom_range(0, 3));
            M_wa      = 5'($urandom_range(0, 3));
            W_wa      = 5'($urandom_range(0, 3));
            D_TuseRs  = 2'($urandom_range(0, 3));
            D_TuseRt  = 2'($urandom_range(0, 3));
            E_Tnew    = 2'($urandom_range(0, 3));
            M_Tnew    = 2'($urandom_range(0, 2));
            D_isMD    = 1'($urandom_range(0, 1));
            E_mdStart = ($urandom_range(0, 7) == 0);
            E_isDiv   = 1'($urandom_range(0, 1));
            #1;
            want = expVec();
            nChecks++;
            if (dutVec() !== want) begin
                nFails++; $display("FAIL random_%0d: got %b want %b", k, dutVec(), want);
            end
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        clearInputs();
        reset = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_priority();
        test_mdu();
        test_reset_mid_div();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
